// File: rtl/updown_count_arbiter.sv
// Round-robin owner of a WIDTH-bit up/down counter: grants one A/B run, steps q once per clock, then pulses done.
// Grant is combinational in IDLE; a run of N steps holds busy for N+1 cycles and refuses requests until back in IDLE.
module updown_count_arbiter #(
   parameter int WIDTH = 4,
   parameter int STEPW = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             dir_a,
   input  logic [STEPW-1:0] steps_a,
   input  logic             req_b,
   input  logic             dir_b,
   input  logic [STEPW-1:0] steps_b,
   input  logic             sat_mode,
   input  logic             clr,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             busy,
   output logic             done,
   output logic             owner,
   output logic             sat_flag,
   output logic [WIDTH-1:0] q
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
   localparam logic [STEPW-1:0] STEP_ONE = STEPW'(1);

   state_t           state_q;
   logic [WIDTH-1:0] count_q, count_d;
   logic [STEPW-1:0] rem_q;
   logic             dir_q;
   logic             owner_q;
   logic             sat_q;
   logic             last_b_q;
   logic             busy_q;
   logic             done_q;

   logic             in_idle;
   logic             sel_a, sel_b;
   logic             win_dir;
   logic [STEPW-1:0] win_steps;
   logic             at_rail;
   logic             blocked;

   // A tie goes to whoever was not served last; a lone request always wins.
   assign in_idle   = (state_q == S_IDLE);
   assign sel_a     = req_a & (~req_b | last_b_q);
   assign sel_b     = req_b & (~req_a | ~last_b_q);
   assign gnt_a     = in_idle & sel_a;
   assign gnt_b     = in_idle & sel_b;
   assign win_dir   = sel_b ? dir_b : dir_a;
   assign win_steps = sel_b ? steps_b : steps_a;

   assign at_rail = dir_q ? (count_q == CNT_MAX) : (count_q == '0);
   assign blocked = sat_mode & at_rail;

   always_comb begin
      count_d = count_q;
      if (in_idle && clr) begin
         count_d = '0;
      end else if (state_q == S_RUN && !blocked) begin
         count_d = dir_q ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         rem_q    <= '0;
         dir_q    <= 1'b0;
         owner_q  <= 1'b0;
         sat_q    <= 1'b0;
         last_b_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         case (state_q)
            S_IDLE: begin
               if (gnt_a || gnt_b) begin
                  dir_q    <= win_dir;
                  rem_q    <= win_steps;
                  owner_q  <= gnt_b;
                  last_b_q <= gnt_b;
                  sat_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  if (win_steps == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               // A blocked step still consumes one unit of the run.
               if (blocked) begin
                  sat_q <= 1'b1;
               end
               rem_q <= rem_q - STEP_ONE;
               if (rem_q == STEP_ONE) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign owner    = owner_q;
   assign sat_flag = sat_q;
   assign q        = count_q;

endmodule

// File: tb/tb_updown_count_arbiter.sv
// Directed bench for updown_count_arbiter: per-cycle vector table plus hand sequences for reset abort and arbitration.
module tb_updown_count_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_a, dir_a, req_b, dir_b, sat_mode, clr;
   logic [3:0] steps_a, steps_b;
   logic       gnt_a, gnt_b, busy, done, owner, sat_flag;
   logic [3:0] q;

   int n_checks = 0;
   int n_fail   = 0;

   updown_count_arbiter #(.WIDTH(4), .STEPW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .dir_a(dir_a), .steps_a(steps_a),
      .req_b(req_b), .dir_b(dir_b), .steps_b(steps_b),
      .sat_mode(sat_mode), .clr(clr),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy), .done(done),
      .owner(owner), .sat_flag(sat_flag), .q(q)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       ra, da;
      logic [3:0] sa;
      logic       rb, db;
      logic [3:0] sb;
      logic       sm, cl;
      logic       ega, egb, ebusy, edone, eown, esat;
      logic [3:0] eq;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input string nm,
                              input logic ra, input logic da, input logic [3:0] sa,
                              input logic rb, input logic db, input logic [3:0] sb,
                              input logic sm, input logic cl,
                              input logic ega, input logic egb, input logic ebusy,
                              input logic edone, input logic eown, input logic esat,
                              input logic [3:0] eq);
      vec_t r;
      r.name = nm; r.ra = ra; r.da = da; r.sa = sa; r.rb = rb; r.db = db; r.sb = sb;
      r.sm = sm; r.cl = cl; r.ega = ega; r.egb = egb; r.ebusy = ebusy;
      r.edone = edone; r.eown = eown; r.esat = esat; r.eq = eq;
      return r;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endfunction

   task automatic drive_idle();
      req_a = 0; dir_a = 0; steps_a = 0;
      req_b = 0; dir_b = 0; steps_b = 0;
      sat_mode = 0; clr = 0;
   endtask

   task automatic apply_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         @(negedge clk);
         req_a = vecs[i].ra; dir_a = vecs[i].da; steps_a = vecs[i].sa;
         req_b = vecs[i].rb; dir_b = vecs[i].db; steps_b = vecs[i].sb;
         sat_mode = vecs[i].sm; clr = vecs[i].cl;
         #1;
         chk({vecs[i].name, ".gnt_a"},    32'(gnt_a),    32'(vecs[i].ega));
         chk({vecs[i].name, ".gnt_b"},    32'(gnt_b),    32'(vecs[i].egb));
         chk({vecs[i].name, ".busy"},     32'(busy),     32'(vecs[i].ebusy));
         chk({vecs[i].name, ".done"},     32'(done),     32'(vecs[i].edone));
         chk({vecs[i].name, ".owner"},    32'(owner),    32'(vecs[i].eown));
         chk({vecs[i].name, ".sat_flag"}, 32'(sat_flag), 32'(vecs[i].esat));
         chk({vecs[i].name, ".q"},        32'(q),        32'(vecs[i].eq));
      end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic wait_done(input string nm, input int budget);
      int k = 0;
      #1;
      while (!done && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk({nm, ".done_seen"}, 32'(done), 32'd1);
   endtask

   task automatic do_run(input string nm, input logic use_b, input logic dir, input logic [3:0] n);
      @(negedge clk);
      if (use_b) begin req_b = 1; dir_b = dir; steps_b = n; end
      else       begin req_a = 1; dir_a = dir; steps_a = n; end
      #1;
      chk({nm, ".gnt_a"}, 32'(gnt_a), 32'(!use_b));
      chk({nm, ".gnt_b"}, 32'(gnt_b), 32'(use_b));
      @(negedge clk);
      drive_idle();
      wait_done(nm, 20);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   int base_t1, base_t2, base_t3, base_t4, base_end;
   logic exp_b;

   initial begin
      // ---- vector table ----
      vecs.push_back(v("rst_idle", 0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 0));
      base_t1 = vecs.size();
      vecs.push_back(v("up5_c0", 1,1,5, 0,0,0, 0,0, 1,0,0,0,0,0, 0));
      vecs.push_back(v("up5_c1", 0,0,0, 0,0,0, 0,0, 0,0,1,0,0,0, 0));
      vecs.push_back(v("up5_c2", 0,0,0, 1,1,3, 0,0, 0,0,1,0,0,0, 1));
      vecs.push_back(v("up5_c3", 0,0,0, 0,0,0, 0,1, 0,0,1,0,0,0, 2));
      vecs.push_back(v("up5_c4", 0,0,0, 0,0,0, 0,0, 0,0,1,0,0,0, 3));
      vecs.push_back(v("up5_c5", 0,0,0, 0,0,0, 0,0, 0,0,1,0,0,0, 4));
      vecs.push_back(v("up5_c6", 1,0,2, 0,0,0, 0,0, 0,0,1,1,0,0, 5));
      vecs.push_back(v("up5_c7", 0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 5));
      base_t2 = vecs.size();
      vecs.push_back(v("wrap_c0", 1,1,3, 0,0,0, 0,0, 1,0,0,0,0,0, 14));
      vecs.push_back(v("wrap_c1", 0,0,0, 0,0,0, 0,0, 0,0,1,0,0,0, 14));
      vecs.push_back(v("wrap_c2", 0,0,0, 0,0,0, 0,0, 0,0,1,0,0,0, 15));
      vecs.push_back(v("wrap_c3", 0,0,0, 0,0,0, 0,0, 0,0,1,0,0,0, 0));
      vecs.push_back(v("wrap_c4", 0,0,0, 0,0,0, 0,0, 0,0,1,1,0,0, 1));
      vecs.push_back(v("wrap_c5", 0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0, 1));
      base_t3 = vecs.size();
      vecs.push_back(v("sat_c0", 1,1,3, 0,0,0, 1,0, 1,0,0,0,0,0, 14));
      vecs.push_back(v("sat_c1", 0,0,0, 0,0,0, 1,0, 0,0,1,0,0,0, 14));
      vecs.push_back(v("sat_c2", 0,0,0, 0,0,0, 1,0, 0,0,1,0,0,0, 15));
      vecs.push_back(v("sat_c3", 0,0,0, 0,0,0, 1,0, 0,0,1,0,0,1, 15));
      vecs.push_back(v("sat_c4", 0,0,0, 0,0,0, 1,0, 0,0,1,1,0,1, 15));
      vecs.push_back(v("sat_c5", 0,0,0, 0,0,0, 1,0, 0,0,0,0,0,1, 15));
      base_t4 = vecs.size();
      vecs.push_back(v("zero_c0", 0,0,0, 1,0,0, 0,0, 0,1,0,0,0,1, 15));
      vecs.push_back(v("zero_c1", 1,1,2, 0,0,0, 0,0, 0,0,1,1,1,0, 15));
      vecs.push_back(v("zero_c2", 0,0,0, 0,0,0, 0,0, 0,0,0,0,1,0, 15));
      base_end = vecs.size();

      // ---- reset ----
      drive_idle();
      rst_n = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("in_reset.q",        32'(q),        32'd0);
      chk("in_reset.busy",     32'(busy),     32'd0);
      chk("in_reset.done",     32'(done),     32'd0);
      chk("in_reset.owner",    32'(owner),    32'd0);
      chk("in_reset.sat_flag", 32'(sat_flag), 32'd0);
      rst_n = 1;

      apply_range(0, base_t2);
      do_run("to14_a", 1'b0, 1'b1, 4'd9);
      @(negedge clk); #1;
      chk("to14_a.q", 32'(q), 32'd14);

      apply_range(base_t2, base_t3);
      do_run("to14_b", 1'b0, 1'b1, 4'd13);
      @(negedge clk); #1;
      chk("to14_b.q", 32'(q), 32'd14);

      apply_range(base_t3, base_end);

      // clear in IDLE with no request
      @(negedge clk); clr = 1; #1;
      chk("clr_idle.before", 32'(q), 32'd15);
      @(negedge clk); clr = 0; #1;
      chk("clr_idle.after", 32'(q), 32'd0);

      do_run("to3", 1'b0, 1'b1, 4'd3);
      @(negedge clk); #1;
      chk("to3.q", 32'(q), 32'd3);

      // down 6 from 3, reset after two steps
      req_a = 1; dir_a = 0; steps_a = 4'd6;
      #1;
      chk("down6.gnt_a", 32'(gnt_a), 32'd1);
      @(negedge clk); drive_idle(); #1;
      chk("down6.c1.q", 32'(q), 32'd3);
      @(negedge clk); #1;
      chk("down6.c2.q", 32'(q), 32'd2);
      @(negedge clk); #1;
      chk("down6.c3.q", 32'(q), 32'd1);
      #2 rst_n = 0;
      #1;
      chk("abort.q",    32'(q),    32'd0);
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         chk("abort.no_done", 32'(done), 32'd0);
      end
      @(negedge clk); clr = 1;
      @(negedge clk); clr = 0; #1;
      chk("post_rst_clr.q", 32'(q), 32'd0);

      do_run("post_rst_b", 1'b1, 1'b1, 4'd2);
      @(negedge clk); #1;
      chk("post_rst_b.q",     32'(q),     32'd2);
      chk("post_rst_b.owner", 32'(owner), 32'd1);

      // both requesting: round-robin after a B run gives A, B, A
      for (int i = 0; i < 3; i++) begin
         exp_b = (i == 1);
         @(negedge clk);
         req_a = 1; dir_a = 1; steps_a = 4'd1;
         req_b = 1; dir_b = 1; steps_b = 4'd1;
         #1;
         chk($sformatf("tie%0d.gnt_a", i), 32'(gnt_a), 32'(!exp_b));
         chk($sformatf("tie%0d.gnt_b", i), 32'(gnt_b), 32'(exp_b));
         @(negedge clk); drive_idle(); #1;
         chk($sformatf("tie%0d.owner", i), 32'(owner), 32'(exp_b));
         chk($sformatf("tie%0d.busy", i),  32'(busy),  32'd1);
         wait_done($sformatf("tie%0d", i), 10);
         @(negedge clk); #1;
         chk($sformatf("tie%0d.q", i), 32'(q), 32'(3 + i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
